// File: rtl/aes128_inv_core.sv
// Iterative AES-128 inverse cipher: forward key expansion, then ten inverse rounds
// (one per cycle), walking the key schedule backwards from round key 10.
module aes128_inv_core #(
  parameter bit READY_PULSE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [127:0] key_i,
  input  logic [127:0] data_i,
  output logic [127:0] data_o,
  output logic         ready_o,
  output logic         busy_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    ARK0  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } fsm_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (x & {8{b[i]}});
      x = {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // InvShiftRows -> InvSubBytes -> AddRoundKey -> optional InvMixColumns
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic mix);
    logic [127:0] sr;
    logic [127:0] t;
    logic [127:0] m;
    sr = {s[127:120], s[23:16],   s[47:40],  s[71:64],
          s[95:88],   s[119:112], s[15:8],   s[39:32],
          s[63:56],   s[87:80],   s[111:104], s[7:0],
          s[31:24],   s[55:48],   s[79:72],  s[103:96]};
    for (int i = 0; i < 16; i++) begin
      t[8*i +: 8] = inv_sbox(sr[8*i +: 8]);
    end
    t = t ^ rk;
    for (int c = 0; c < 4; c++) begin
      m[32*c +: 32] = inv_mix_col(t[32*c +: 32]);
    end
    return mix ? m : t;
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] data_q, data_d;
  logic         ready_q, ready_d;
  logic         busy_q, busy_d;

  logic [31:0]  kx_word_s;
  logic [31:0]  kx_t_s;
  logic [127:0] key_fwd_s;
  logic [127:0] key_inv_s;
  logic [127:0] round_s;

  // Shared 4-S-box key step: forward uses w3, backward recovers old w3 as w3^w2
  always_comb begin
    if (fsm_q == KEXP) begin
      kx_word_s = key_q[31:0];
    end else begin
      kx_word_s = key_q[31:0] ^ key_q[63:32];
    end
    kx_t_s = {sbox(kx_word_s[23:16]), sbox(kx_word_s[15:8]), sbox(kx_word_s[7:0]),
              sbox(kx_word_s[31:24])} ^ {rcon(cnt_q), 24'h000000};
    key_fwd_s[127:96] = key_q[127:96] ^ kx_t_s;
    key_fwd_s[95:64]  = key_q[95:64] ^ key_fwd_s[127:96];
    key_fwd_s[63:32]  = key_q[63:32] ^ key_fwd_s[95:64];
    key_fwd_s[31:0]   = key_q[31:0] ^ key_fwd_s[63:32];
    key_inv_s = {key_q[127:96] ^ kx_t_s, key_q[95:64] ^ key_q[127:96],
                 key_q[63:32] ^ key_q[95:64], kx_word_s};
    round_s = inv_round(state_q, key_inv_s, cnt_q != 4'd1);
  end

  // Next-state and next-output logic for the sequencer
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    key_d   = key_q;
    data_d  = data_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (fsm_q)
      IDLE, DONE: begin
        if (load_i) begin
          key_d   = key_i;
          state_d = data_i;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = 4'd1;
          fsm_d   = KEXP;
        end else if (READY_PULSE) begin
          ready_d = 1'b0;
        end else begin
          ready_d = ready_q;
        end
      end
      KEXP: begin
        key_d = key_fwd_s;
        if (cnt_q == 4'd10) begin
          fsm_d = ARK0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ARK0: begin
        state_d = state_q ^ key_q;
        cnt_d   = 4'd10;
        fsm_d   = ROUND;
      end
      ROUND: begin
        // counter 0 is the output register stage after the last round
        if (cnt_q == 4'd0) begin
          data_d  = state_q;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          fsm_d   = DONE;
        end else begin
          key_d   = key_inv_s;
          state_d = round_s;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      cnt_q   <= 4'd0;
      state_q <= 128'h0;
      key_q   <= 128'h0;
      data_q  <= 128'h0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      key_q   <= key_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign data_o  = data_q;
  assign ready_o = ready_q;
  assign busy_o  = busy_q;

endmodule
